// File: rtl/inst_dispatch_ctrl.sv
// Instruction dispatch controller: pops one word from the instruction FIFO, holds it for decode,
// starts the raster or fill engine, and waits for its done under a watchdog.
module inst_dispatch_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_BITS       = 16
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                fifo_empty,
    input  logic [81:0]         fifo_data,
    output logic                fifo_r_enable,
    input  logic                halt,
    input  logic                raster_done,
    input  logic                fill_done,
    input  logic                clear_err,
    output logic [81:0]         inst_word,
    output logic                raster_start,
    output logic                fill_start,
    output logic                busy,
    output logic                timeout_err,
    output logic [CNT_BITS-1:0] inst_count
);

    localparam int unsigned WD_BITS = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_DISPATCH,
        S_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [81:0]           r_word;
    logic [WD_BITS-1:0]    r_wdog;
    logic [CNT_BITS-1:0]   r_count;
    logic                  r_err;
    logic                  w_done_sel;
    logic                  w_expire;

    // Only the engine selected by inst_type may end the WAIT state.
    always_comb begin
        w_next        = r_state;
        w_done_sel    = r_word[81] ? fill_done : raster_done;
        w_expire      = (r_wdog == WD_BITS'(TIMEOUT_CYCLES - 1));
        fifo_r_enable = 1'b0;
        raster_start  = 1'b0;
        fill_start    = 1'b0;
        busy          = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (!fifo_empty && !halt) w_next = S_FETCH;
            end
            S_FETCH: begin
                fifo_r_enable = 1'b1;
                w_next        = S_LOAD;
            end
            S_LOAD: begin
                w_next = S_DISPATCH;
            end
            S_DISPATCH: begin
                raster_start = !r_word[81];
                fill_start   = r_word[81];
                w_next       = S_WAIT;
            end
            S_WAIT: begin
                if (w_done_sel || w_expire) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_wdog  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_LOAD) r_word <= fifo_data;

            if (r_state == S_DISPATCH) begin
                r_wdog <= '0;
            end else if (r_state == S_WAIT && !w_done_sel && !w_expire) begin
                r_wdog <= r_wdog + 1'b1;
            end

            if (r_state == S_WAIT && w_done_sel) r_count <= r_count + 1'b1;

            // A timeout on the same cycle as clear_err leaves the flag set.
            if (r_state == S_WAIT && !w_done_sel && w_expire) begin
                r_err <= 1'b1;
            end else if (clear_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign inst_word   = r_word;
    assign timeout_err = r_err;
    assign inst_count  = r_count;

endmodule

// File: tb/tb_inst_dispatch_ctrl.sv
// Scoreboard bench for inst_dispatch_ctrl: FIFO model feeds words, a monitor checks each start
// pulse against queued expectations, directed checks cover timing, halt, watchdog and counter.
module tb_inst_dispatch_ctrl;

    localparam logic [81:0] W1 = {34'd0, 48'h000_000_000_ABC};
    localparam logic [81:0] W2 = {1'b1, 1'b0, 2'd3, 2'd1, 4'hA, 24'h123456, 48'h0AB_CDE_F01_234};
    localparam logic [81:0] W3 = {1'b0, 1'b1, 2'd2, 2'd0, 4'h5, 24'hFF00FF, 48'h111_222_333_444};
    localparam logic [81:0] W4 = {1'b1, 1'b1, 2'd1, 2'd3, 4'hF, 24'h00FF00, 48'h555_666_777_888};
    localparam logic [81:0] W5 = {1'b0, 1'b0, 2'd0, 2'd2, 4'h3, 24'hABCDEF, 48'hFFF_000_FFF_000};

    logic        clk;
    logic        n_rst;
    logic        fifo_empty;
    logic [81:0] fifo_data;
    logic        fifo_r_enable;
    logic        halt;
    logic        raster_done;
    logic        fill_done;
    logic        clear_err;
    logic [81:0] inst_word;
    logic        raster_start;
    logic        fill_start;
    logic        busy;
    logic        timeout_err;
    logic [1:0]  inst_count;

    inst_dispatch_ctrl #(.TIMEOUT_CYCLES(8), .CNT_BITS(2)) dut (
        .clk(clk), .n_rst(n_rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_r_enable(fifo_r_enable), .halt(halt), .raster_done(raster_done),
        .fill_done(fill_done), .clear_err(clear_err), .inst_word(inst_word),
        .raster_start(raster_start), .fill_start(fill_start), .busy(busy),
        .timeout_err(timeout_err), .inst_count(inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: read data appears the cycle after the pop.
    logic [81:0] fmem [32];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_r_enable) begin
            fifo_data <= fmem[rd_ptr % 32];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    typedef struct packed {
        logic        is_fill;
        logic [81:0] word;
    } disp_t;
    disp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [81:0] act, input logic [81:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic is_fill, input logic [81:0] w);
        disp_t e;
        fmem[wr_ptr % 32] = w;
        wr_ptr = wr_ptr + 1;
        e.is_fill = is_fill;
        e.word    = w;
        exp_q.push_back(e);
    endtask

    task automatic drive_done(input logic is_fill, input logic v);
        if (is_fill) fill_done = v;
        else         raster_done = v;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(raster_start || fill_start) && cyc < 20);
        chk("start_seen", 82'(raster_start | fill_start), 82'd1);
    endtask

    task automatic monitor();
        disp_t e;
        forever begin
            @(negedge clk);
            if (raster_start || fill_start) begin
                chk("start_exclusive", 82'(raster_start & fill_start), 82'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_start: got start with word %h, expected none", inst_word);
                end else begin
                    e = exp_q.pop_front();
                    chk("start_type", 82'(fill_start), 82'(e.is_fill));
                    chk("dispatch_word", inst_word, e.word);
                end
            end
        end
    endtask

    initial begin
        int cyc;
        n_rst = 1'b0; halt = 1'b0; raster_done = 1'b0; fill_done = 1'b0; clear_err = 1'b0;
        fork
            monitor();
        join_none

        // Reset with a word waiting
        push_word(1'b0, W1);
        tick();
        chk("rst_no_pop", 82'(fifo_r_enable), 82'd0);
        tick();
        chk("rst_pop", 82'(fifo_r_enable), 82'd0);
        chk("rst_rstart", 82'(raster_start), 82'd0);
        chk("rst_fstart", 82'(fill_start), 82'd0);
        chk("rst_busy", 82'(busy), 82'd0);
        chk("rst_err", 82'(timeout_err), 82'd0);
        chk("rst_count", 82'(inst_count), 82'd0);
        chk("rst_word", inst_word, 82'd0);
        n_rst = 1'b1;
        tick();
        chk("first_pop", 82'(fifo_r_enable), 82'd1);

        // Raster dispatch, done 4 cycles after start
        tick();
        chk("load_no_pop", 82'(fifo_r_enable), 82'd0);
        tick();
        chk("raster_start", 82'(raster_start), 82'd1);
        chk("raster_nofill", 82'(fill_start), 82'd0);
        chk("raster_word", inst_word, W1);
        tick();
        chk("start_one_cycle", 82'(raster_start), 82'd0);
        tick();
        tick();
        tick();
        raster_done = 1'b1;
        chk("busy_at_done", 82'(busy), 82'd1);
        tick();
        raster_done = 1'b0;
        chk("busy_after_done", 82'(busy), 82'd0);
        chk("count_raster", 82'(inst_count), 82'd1);
        chk("word_hold", inst_word, W1);

        // Fill dispatch with a stray raster_done
        push_word(1'b1, W2);
        wait_start(cyc);
        chk("fill_latency", 82'(cyc), 82'd3);
        tick();
        raster_done = 1'b1;
        tick();
        raster_done = 1'b0;
        chk("wrong_done_ignored", 82'(busy), 82'd1);
        tick();
        tick();
        fill_done = 1'b1;
        chk("busy_before_fill_done", 82'(busy), 82'd1);
        tick();
        fill_done = 1'b0;
        chk("fill_idle", 82'(busy), 82'd0);
        chk("count_fill", 82'(inst_count), 82'd2);

        // Halt
        halt = 1'b1;
        do_reset();
        push_word(1'b0, W3);
        push_word(1'b1, W4);
        push_word(1'b0, W5);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_no_pop", 82'(fifo_r_enable), 82'd0);
        end
        halt = 1'b0;
        wait_start(cyc);
        chk("halt_release_latency", 82'(cyc), 82'd3);
        tick();
        halt = 1'b1;
        tick();
        raster_done = 1'b1;
        tick();
        raster_done = 1'b0;
        chk("halt_inflight_done", 82'(inst_count), 82'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt_hold_pop", 82'(fifo_r_enable), 82'd0);
            chk("halt_hold_busy", 82'(busy), 82'd0);
        end
        halt = 1'b0;
        wait_start(cyc);
        tick();
        fill_done = 1'b1;
        tick();
        fill_done = 1'b0;
        wait_start(cyc);
        chk("back_to_back", 82'(cyc), 82'd3);
        tick();
        raster_done = 1'b1;
        tick();
        raster_done = 1'b0;
        chk("halt_count", 82'(inst_count), 82'd3);

        // Watchdog: plain timeout, then clear
        do_reset();
        push_word(1'b0, W3);
        wait_start(cyc);
        for (int i = 0; i < 8; i++) tick();
        chk("pre_expiry_err", 82'(timeout_err), 82'd0);
        chk("pre_expiry_busy", 82'(busy), 82'd1);
        tick();
        chk("timeout_err", 82'(timeout_err), 82'd1);
        chk("timeout_idle", 82'(busy), 82'd0);
        chk("timeout_count", 82'(inst_count), 82'd0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("clear_err", 82'(timeout_err), 82'd0);

        // Done on the expiry cycle wins
        push_word(1'b1, W4);
        wait_start(cyc);
        for (int i = 0; i < 8; i++) tick();
        fill_done = 1'b1;
        tick();
        fill_done = 1'b0;
        chk("expiry_done_err", 82'(timeout_err), 82'd0);
        chk("expiry_done_count", 82'(inst_count), 82'd1);

        // Timeout with clear_err held: set wins
        push_word(1'b0, W5);
        wait_start(cyc);
        for (int i = 0; i < 8; i++) tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("set_beats_clear", 82'(timeout_err), 82'd1);
        chk("set_beats_clear_cnt", 82'(inst_count), 82'd1);

        // Counter wrap at 2 bits, done in DISPATCH ignored
        do_reset();
        chk("reset_clears_err", 82'(timeout_err), 82'd0);
        for (int i = 0; i < 5; i++) begin
            logic f;
            f = (i % 2 == 1);
            push_word(f, (i % 2 == 1) ? W4 : W3);
            wait_start(cyc);
            if (i == 0) begin
                drive_done(f, 1'b1);
                tick();
                drive_done(f, 1'b0);
                chk("dispatch_done_ignored", 82'(busy), 82'd1);
            end else begin
                tick();
            end
            drive_done(f, 1'b1);
            tick();
            drive_done(f, 1'b0);
            chk("wrap_count", 82'(inst_count), 82'((i + 1) % 4));
        end

        // Reset during WAIT, then a late done
        push_word(1'b0, W5);
        wait_start(cyc);
        tick();
        n_rst = 1'b0;
        tick();
        chk("midrst_busy", 82'(busy), 82'd0);
        chk("midrst_count", 82'(inst_count), 82'd0);
        chk("midrst_word", inst_word, 82'd0);
        chk("midrst_start", 82'(raster_start), 82'd0);
        n_rst = 1'b1;
        raster_done = 1'b1;
        tick();
        raster_done = 1'b0;
        tick();
        chk("late_done_count", 82'(inst_count), 82'd0);
        chk("late_done_busy", 82'(busy), 82'd0);

        chk("scoreboard_drained", 82'(exp_q.size() == 0), 82'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_dispatch_ctrl.md
Name: inst_dispatch_ctrl

Overview:
- Sequences the instruction path between the instruction FIFO and the draw engines.
- Pops one 82-bit instruction word from the FIFO and holds it stable on inst_word for decode_block.
- Issues a one-cycle start pulse to the raster engine or the fill engine, then waits for that engine's done.
- Provides halt, a done-timeout watchdog with a sticky error flag, and a completed-instruction counter.

Parameters:
- TIMEOUT_CYCLES, 1024: number of WAIT cycles without done before the instruction is abandoned.
- CNT_BITS, 16: width of inst_count.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- n_rst  in  1  synchronous, active-low reset.
- fifo_empty  in  1  instruction FIFO empty flag.
- fifo_data  in  82  FIFO read data; valid the cycle after fifo_r_enable.
- fifo_r_enable  out  1  one-cycle FIFO pop.
- halt  in  1  blocks new fetches while high.
- raster_done  in  1  raster engine completion pulse.
- fill_done  in  1  fill engine completion pulse.
- clear_err  in  1  clears timeout_err.
- inst_word  out  82  latched instruction, drives decode_block fifo_data.
- raster_start  out  1  one-cycle start to raster engine.
- fill_start  out  1  one-cycle start to fill engine.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  sticky watchdog error.
- inst_count  out  CNT_BITS  count of instructions completed with done.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on n_rst.
- Reset values: state IDLE; inst_word 0; all strobes 0; busy 0; timeout_err 0; inst_count 0; watchdog counter 0.
- Reset mid-operation: the controller returns to IDLE on the next edge, drops any start pulse, and abandons the instruction without counting it.
- Word layout:
  - [81] inst_type (0 = raster, 1 = fill)
  - [80] fill_type
  - [79:78] layer_num
  - [77:76] texture_code
  - [75:72] alpha
  - [71:48] color_code
  - [47:0] coordinates (4 x 12-bit)
  - The controller uses only bit [81]. All other fields pass through untouched.
- States: IDLE, FETCH, LOAD, DISPATCH, WAIT.
- IDLE:
  - If !fifo_empty && !halt, go to FETCH. Otherwise stay.
  - halt is sampled only in IDLE. An in-flight instruction always completes.
- FETCH:
  - fifo_r_enable = 1 for exactly this cycle. Go to LOAD unconditionally.
  - fifo_empty is not re-checked here.
- LOAD:
  - fifo_data is valid. Latch it into inst_word on the exiting edge, then go to DISPATCH.
  - inst_word holds until the next LOAD.
- DISPATCH:
  - raster_start = 1 if inst_word[81] = 0; fill_start = 1 if it is 1. Never both.
  - Clear the watchdog and go to WAIT.
- WAIT:
  - Only the selected engine's done is honoured. The other engine's done is ignored.
  - Done in the DISPATCH cycle is ignored.
  - On selected done: inst_count += 1, wrapping at 2^CNT_BITS, then go to IDLE.
  - Otherwise the watchdog increments. When it reaches TIMEOUT_CYCLES-1 without done: set timeout_err, go to IDLE, do not increment inst_count.
  - If done arrives on the same cycle as expiry, done wins and there is no error.
- Latency: fifo_empty sampled low in IDLE at cycle N gives:
  - fifo_r_enable at N+1
  - inst_word valid from N+3
  - start pulse at N+3
  - earliest return to IDLE at N+5 (done seen at N+4)
- Throughput: one instruction per at least 5 cycles. No pipelining.
- timeout_err:
  - Cleared by clear_err.
  - If clear_err and a new timeout occur in the same cycle, set wins.
  - Does not block further fetches.

Test Plan:
- Reset: hold n_rst = 0 for 2 cycles with fifo_empty = 0 -> all outputs 0, no fifo_r_enable; first fifo_r_enable exactly 1 cycle after n_rst rises.
- Raster dispatch: FIFO word 82'h0_0000_0000_0000_0000_0ABC (bit81 = 0); raster_done 4 cycles after start -> single fifo_r_enable, inst_word equals word from LOAD on, one raster_start pulse at N+3, fill_start never high, inst_count = 1, busy falls the cycle after done.
- Fill dispatch and wrong-engine done: word with bit81 = 1; raster_done pulsed during WAIT, fill_done 3 cycles later -> one fill_start pulse, raster_done ignored, return to IDLE only after fill_done, inst_count increments once.
- Halt: halt = 1 with 3 words queued -> no fifo_r_enable. Raise halt during WAIT of a fetched instruction -> that instruction completes, no further fetch until halt = 0, then remaining 2 words dispatched back-to-back, inst_count = 3.
- Timeout: TIMEOUT_CYCLES = 8, no done -> timeout_err = 1 after 8 WAIT cycles, IDLE, inst_count unchanged. clear_err asserted -> timeout_err = 0 next cycle. Separately, done on the expiry cycle -> no error and count increments.
- Counter wrap and reset mid-WAIT: CNT_BITS = 2, 5 completed instructions -> inst_count = 1. n_rst low during WAIT -> IDLE, inst_count = 0, late done ignored.
